// File: rtl/mul_out_ctrl.sv
// Output-side controller for the multiplier: holds the 2*DW-bit product and
// streams it as two DW-bit beats, locking the input stage until it drains.
module mul_out_ctrl #(
    parameter int DW        = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            p_valid,
    input  logic [2*DW-1:0] p,
    output logic            locked,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            dout_last,
    output logic            overflow,
    input  logic            clr_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [2*DW-1:0]   hold_r, hold_nxt_s;
    logic [DW-1:0]     dout_nxt_s;
    logic              valid_nxt_s, last_nxt_s, locked_nxt_s, ovf_nxt_s;
    logic              ovf_set_s, xfer_s;

    function automatic logic [DW-1:0] first_beat(input logic [2*DW-1:0] h);
        if (LSB_FIRST) begin
            return h[DW-1:0];
        end else begin
            return h[2*DW-1:DW];
        end
    endfunction

    function automatic logic [DW-1:0] second_beat(input logic [2*DW-1:0] h);
        if (LSB_FIRST) begin
            return h[2*DW-1:DW];
        end else begin
            return h[DW-1:0];
        end
    endfunction

    assign xfer_s = dout_valid && dout_ready;

    // Next-state, hold capture, overflow detection and next registered outputs
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        ovf_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (p_valid) begin
                    hold_nxt_s  = p;
                    state_nxt_s = SEND0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SEND0: begin
                ovf_set_s = p_valid;
                if (xfer_s) begin
                    state_nxt_s = SEND1;
                end else begin
                    state_nxt_s = SEND0;
                end
            end
            SEND1: begin
                // A product arriving on the final transfer is taken without a bubble
                if (xfer_s && p_valid) begin
                    hold_nxt_s  = p;
                    state_nxt_s = SEND0;
                end else if (xfer_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    ovf_set_s   = p_valid;
                    state_nxt_s = SEND1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                hold_nxt_s  = {(2*DW){1'b0}};
            end
        endcase

        dout_nxt_s   = {DW{1'b0}};
        valid_nxt_s  = 1'b0;
        last_nxt_s   = 1'b0;
        locked_nxt_s = 1'b0;
        case (state_nxt_s)
            SEND0: begin
                dout_nxt_s   = first_beat(hold_nxt_s);
                valid_nxt_s  = 1'b1;
                locked_nxt_s = 1'b1;
            end
            SEND1: begin
                dout_nxt_s   = second_beat(hold_nxt_s);
                valid_nxt_s  = 1'b1;
                last_nxt_s   = 1'b1;
                locked_nxt_s = 1'b1;
            end
            default: begin
                dout_nxt_s   = {DW{1'b0}};
                valid_nxt_s  = 1'b0;
                last_nxt_s   = 1'b0;
                locked_nxt_s = 1'b0;
            end
        endcase

        if (ovf_set_s) begin
            ovf_nxt_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = overflow;
        end
    end

    // State, hold register and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_r     <= {(2*DW){1'b0}};
            dout       <= {DW{1'b0}};
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            locked     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            hold_r     <= hold_nxt_s;
            dout       <= dout_nxt_s;
            dout_valid <= valid_nxt_s;
            dout_last  <= last_nxt_s;
            locked     <= locked_nxt_s;
            overflow   <= ovf_nxt_s;
        end
    end

endmodule
